// File: rtl/rr_arb_mux.sv
// Round-robin arbitrated N-channel mux with valid/ready on every port and one output register.
// Optional packet locking is enabled by defining ARB_MUX_PACKET_EN (adds in_last/out_last).
module rr_arb_mux #(
  parameter int WIDTH = 16,
  parameter int NCH   = 16,
  localparam int SELW = $clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
`ifdef ARB_MUX_PACKET_EN
  input  logic [NCH-1:0]       in_last,
  output logic                 out_last,
`endif
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SELW-1:0]      out_sel
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic [SELW-1:0]  sel_q, sel_d;
  logic [SELW-1:0]  ptr_q, ptr_d;
  logic             load;
  logic             gnt_found;
  int               gnt_idx;
  int               scan_idx;
  logic [WIDTH-1:0] gnt_data;
  logic             gnt_last;
`ifdef ARB_MUX_PACKET_EN
  logic             lock_q, lock_d;
  logic             last_q, last_d;
`endif

  // reset gating keeps in_ready low while rst_n is asserted
  assign load = rst_n & (~valid_q | out_ready);

  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = 0;
    scan_idx  = 0;
    gnt_data  = '0;
    gnt_last  = 1'b1;
    for (int k = 0; k < NCH; k++) begin
      scan_idx = int'(ptr_q) + k;
      if (scan_idx >= NCH) scan_idx = scan_idx - NCH;
`ifdef ARB_MUX_PACKET_EN
      // a locked packet owns the output until its last beat, even when idle
      if (!gnt_found && in_valid[scan_idx] && (!lock_q || scan_idx == int'(sel_q))) begin
        gnt_last = in_last[scan_idx];
`else
      if (!gnt_found && in_valid[scan_idx]) begin
`endif
        gnt_found = 1'b1;
        gnt_idx   = scan_idx;
        gnt_data  = in_data[scan_idx*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    in_ready = '0;
    data_d   = data_q;
    valid_d  = valid_q;
    sel_d    = sel_q;
    ptr_d    = ptr_q;
`ifdef ARB_MUX_PACKET_EN
    lock_d   = lock_q;
    last_d   = last_q;
`endif
    if (load) begin
      valid_d = gnt_found;
      if (gnt_found) begin
        in_ready[gnt_idx] = 1'b1;
        data_d = gnt_data;
        sel_d  = SELW'(gnt_idx);
`ifdef ARB_MUX_PACKET_EN
        last_d = gnt_last;
        lock_d = ~gnt_last;
`endif
        if (gnt_last) ptr_d = (gnt_idx == NCH-1) ? '0 : SELW'(gnt_idx + 1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      sel_q   <= '0;
      ptr_q   <= '0;
`ifdef ARB_MUX_PACKET_EN
      lock_q  <= 1'b0;
      last_q  <= 1'b0;
`endif
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
`ifdef ARB_MUX_PACKET_EN
      lock_q  <= lock_d;
      last_q  <= last_d;
`endif
    end
  end

  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign out_sel   = sel_q;
`ifdef ARB_MUX_PACKET_EN
  assign out_last  = last_q;
`endif

endmodule

// File: tb/tb_rr_arb_mux.sv
// Directed bench for rr_arb_mux: a 16-channel and a 5-channel instance with hand-computed expectations.
module tb_rr_arb_mux;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;

  logic [16*16-1:0] in_data;
  logic [15:0]      in_valid = '0;
  logic [15:0]      in_ready;
  logic [15:0]      in_last = '1;
  logic [15:0]      out_data;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [3:0]       out_sel;
  logic             out_last;

  logic [5*16-1:0]  in_data5;
  logic [4:0]       in_valid5 = '0;
  logic [4:0]       in_ready5;
  logic [4:0]       in_last5 = '1;
  logic [15:0]      out_data5;
  logic             out_valid5;
  logic [2:0]       out_sel5;
  logic             out_last5;

  always #5 clk = ~clk;

  rr_arb_mux #(.WIDTH(16), .NCH(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
`ifdef ARB_MUX_PACKET_EN
    .in_last(in_last), .out_last(out_last),
`endif
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_sel(out_sel));

  rr_arb_mux #(.WIDTH(16), .NCH(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data5), .in_valid(in_valid5), .in_ready(in_ready5),
`ifdef ARB_MUX_PACKET_EN
    .in_last(in_last5), .out_last(out_last5),
`endif
    .out_data(out_data5), .out_valid(out_valid5), .out_ready(1'b1), .out_sel(out_sel5));

`ifndef ARB_MUX_PACKET_EN
  assign out_last  = 1'b0;
  assign out_last5 = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) in_data[i*16 +: 16] = 16'hA000 + 16'(i);
    for (int i = 0; i < 5; i++) in_data5[i*16 +: 16] = 16'hA000 + 16'(i);

    // reset state, with inputs already valid
    in_valid = '1;
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_sel", 32'(out_sel), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_in_ready", 32'(in_ready), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("first_in_ready", 32'(in_ready), 32'h1);

    // all valid: sweep 0..15 then wrap to 0, no bubbles
    for (int i = 0; i <= 16; i++) begin
      tick();
      chk("sweep_valid", 32'(out_valid), 1);
      chk("sweep_sel", 32'(out_sel), 32'(i % 16));
      chk("sweep_data", 32'(out_data), 32'h0000A000 + 32'(i % 16));
      chk("sweep_ready", 32'(in_ready), 32'h1 << ((i + 1) % 16));
    end

    // ptr is 1; a lone ch2 beat moves it to 3
    in_valid = 16'h0004;
    tick();
    chk("ptr_set_sel", 32'(out_sel), 2);
    in_valid = 16'h0024;
    #1;
    chk("wrap_first_ready", 32'(in_ready), 32'h20);
    tick();
    chk("wrap_first_sel", 32'(out_sel), 5);
    chk("wrap_first_data", 32'(out_data), 32'hA005);
    chk("wrap_second_ready", 32'(in_ready), 32'h04);
    tick();
    chk("wrap_second_sel", 32'(out_sel), 2);

    // backpressure: beat from ch2 held, ptr at 3
    in_valid  = '1;
    out_ready = 1'b0;
    #1;
    chk("stall_ready0", 32'(in_ready), 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("stall_valid", 32'(out_valid), 1);
      chk("stall_sel", 32'(out_sel), 2);
      chk("stall_data", 32'(out_data), 32'hA002);
      chk("stall_ready", 32'(in_ready), 0);
    end
    out_ready = 1'b1;
    #1;
    chk("drain_refill_ready", 32'(in_ready), 32'h08);
    tick();
    chk("refill_valid", 32'(out_valid), 1);
    chk("refill_sel", 32'(out_sel), 3);
    chk("refill_data", 32'(out_data), 32'hA003);

    // idle inputs: output empties, data/sel hold
    in_valid = '0;
    tick();
    chk("idle_valid", 32'(out_valid), 0);
    chk("idle_sel", 32'(out_sel), 3);
    chk("idle_data", 32'(out_data), 32'hA003);

    // mid-traffic reset
    in_valid = '1;
    tick();
    chk("pre_rst_sel", 32'(out_sel), 4);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(out_valid), 0);
    chk("midrst_sel", 32'(out_sel), 0);
    chk("midrst_ready", 32'(in_ready), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("postrst_ready", 32'(in_ready), 32'h1);
    tick();
    chk("postrst_sel", 32'(out_sel), 0);
    in_valid = '0;

    // NCH=5 wraps at 5
    in_valid5 = '1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("nch5_valid", 32'(out_valid5), 1);
      chk("nch5_sel", 32'(out_sel5), 32'(i % 5));
      chk("nch5_data", 32'(out_data5), 32'hA000 + 32'(i % 5));
    end
    in_valid5 = '0;

`ifdef ARB_MUX_PACKET_EN
    rst_n = 1'b0;
    #1;
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 16'h0001;
    tick();
    chk("pkt_pre_sel", 32'(out_sel), 0);
    in_valid = 16'h0003;
    in_last  = 16'hFFFD;
    tick();
    chk("pkt_b1_sel", 32'(out_sel), 1);
    chk("pkt_b1_last", 32'(out_last), 0);
    in_valid = 16'h0001;
    #1;
    chk("pkt_idle_ready", 32'(in_ready), 0);
    tick();
    chk("pkt_idle_valid", 32'(out_valid), 0);
    in_valid = 16'h0003;
    tick();
    chk("pkt_b2_sel", 32'(out_sel), 1);
    chk("pkt_b2_last", 32'(out_last), 0);
    in_last = '1;
    tick();
    chk("pkt_b3_sel", 32'(out_sel), 1);
    chk("pkt_b3_last", 32'(out_last), 1);
    in_valid = 16'h0001;
    tick();
    chk("pkt_after_sel", 32'(out_sel), 0);
    chk("pkt_after_valid", 32'(out_valid), 1);
    in_valid = '0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
